// File: rtl/sync_counter_ctrl.sv
// Measurement sequencer for an external counter block: clears it, lets it run for
// a programmed gate window, freezes it and captures the crossed-over results.
module sync_counter_ctrl #(
  parameter int COUNTER_A_BITS    = 32,
  parameter int COUNTER_B_BITS    = 32,
  parameter int WINDOW_BITS       = 32,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int SETTLE_CYCLES     = 8
) (
  input  logic                      axi_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      continuous,
  input  logic [WINDOW_BITS-1:0]    window_len,
  input  logic [COUNTER_A_BITS-1:0] counter_a_result,
  input  logic [COUNTER_B_BITS-1:0] counter_b_result,
  output logic                      cnt_reset,
  output logic                      cnt_snapshot,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err,
  output logic [COUNTER_A_BITS-1:0] result_a,
  output logic [COUNTER_B_BITS-1:0] result_b,
  output logic                      result_valid,
  output logic [15:0]               meas_count
);

  localparam int HOLD_W   = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMALL_W  = (HOLD_W > SETTLE_W) ? HOLD_W : SETTLE_W;
  localparam int CNT_W    = (WINDOW_BITS > SMALL_W) ? WINDOW_BITS : SMALL_W;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RELEASE,
    S_MEASURE,
    S_FREEZE,
    S_CAPTURE
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          dwell_q, dwell_d;
  logic [WINDOW_BITS-1:0]    window_q, window_d;
  logic                      cfg_err_q, cfg_err_d;
  logic [COUNTER_A_BITS-1:0] result_a_q;
  logic [COUNTER_B_BITS-1:0] result_b_q;
  logic                      result_valid_q;
  logic [15:0]               meas_count_q;

  logic dwell_done;
  logic latch_results;
  logic clear_valid;
  logic count_inc;

  assign dwell_done = (dwell_q == '0);

  // The shared dwell counter is loaded with (length - 1) on entry to each timed
  // state, so a state lasts exactly its programmed number of cycles.
  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    window_d      = window_q;
    cfg_err_d     = 1'b0;
    latch_results = 1'b0;
    clear_valid   = 1'b0;
    count_inc     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (window_len != '0) begin
            state_d     = S_CLEAR;
            dwell_d     = HOLD_LOAD;
            window_d    = window_len;
            clear_valid = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (dwell_done) begin
          state_d = S_RELEASE;
          dwell_d = SETTLE_LOAD;
        end else begin
          dwell_d = dwell_q - CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (dwell_done) begin
          state_d = S_MEASURE;
          dwell_d = CNT_W'(window_q) - CNT_W'(1);
        end else begin
          dwell_d = dwell_q - CNT_W'(1);
        end
      end
      S_MEASURE: begin
        if (dwell_done) begin
          state_d = S_FREEZE;
          dwell_d = SETTLE_LOAD;
        end else begin
          dwell_d = dwell_q - CNT_W'(1);
        end
      end
      S_FREEZE: begin
        if (dwell_done) begin
          state_d       = S_CAPTURE;
          latch_results = 1'b1;
        end else begin
          dwell_d = dwell_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        // Abort here still completes the run; it only suppresses re-arming.
        count_inc = 1'b1;
        if (continuous && !abort) begin
          state_d = S_CLEAR;
          dwell_d = HOLD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE) && (state_q != S_CAPTURE)) begin
      state_d       = S_IDLE;
      latch_results = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      dwell_q        <= '0;
      window_q       <= '0;
      cfg_err_q      <= 1'b0;
      result_a_q     <= '0;
      result_b_q     <= '0;
      result_valid_q <= 1'b0;
      meas_count_q   <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      window_q  <= window_d;
      cfg_err_q <= cfg_err_d;
      if (latch_results) begin
        result_a_q     <= counter_a_result;
        result_b_q     <= counter_b_result;
        result_valid_q <= 1'b1;
      end else if (clear_valid) begin
        result_valid_q <= 1'b0;
      end
      if (count_inc) begin
        meas_count_q <= meas_count_q + 16'd1;
      end
    end
  end

  assign cnt_reset    = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign cnt_snapshot = (state_q == S_FREEZE) || (state_q == S_CAPTURE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_CAPTURE);
  assign cfg_err      = cfg_err_q;
  assign result_a     = result_a_q;
  assign result_b     = result_b_q;
  assign result_valid = result_valid_q;
  assign meas_count   = meas_count_q;

endmodule
